sine_cos_cross_detector: RTL and testbench
==========================================

Name: sine_cos_cross_detector

Overview:
- Streaming monitor for the sine_cos generator outputs.
- Compares two WIDTH-bit samples (a = sine, b = cos) each enabled cycle, with optional signed interpretation and a hysteresis band.
- Reports registered eq/lt/gt, single-cycle rise/fall crossing pulses, a running crossing count, and the period between consecutive rising crossings.
- Successor to the bare combinational comparator: one instance sits between the generator and the debug/capture logic.

Parameters:
- WIDTH, 16, sample width of a and b.
- SIGNED, 1, 1 = two's-complement compare; 0 = unsigned.
- HYST, 0, hysteresis magnitude in LSBs; unsigned, must be < 2^(WIDTH-1).
- CNT_WIDTH, 16, width of cross_count, the period counter and period.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  sample-valid; a/b are consumed only when en=1.
- clear  input  1  synchronous clear of count/period state; FSM returns to INIT.
- a  input  WIDTH  sample A (sine).
- b  input  WIDTH  sample B (cos).
- eq  output  1  registered a==b of last enabled sample.
- lt  output  1  registered a<b.
- gt  output  1  registered a>b.
- rise  output  1  one-cycle pulse: a crossed above b (beyond HYST).
- fall  output  1  one-cycle pulse: a crossed below b (beyond HYST).
- cross_count  output  CNT_WIDTH  total rise+fall events; wraps modulo 2^CNT_WIDTH.
- period  output  CNT_WIDTH  enabled-sample count between last two rises.
- period_valid  output  1  one-cycle pulse when period updates.
- period_sat  output  1  sticky: period counter saturated since last clear.

Behaviour:
- Reset (reset=0, async):
  - eq=lt=gt=0, rise=fall=0.
  - cross_count=0, period=0, period_valid=0, period_sat=0.
  - FSM=INIT, internal sample counter=0, have_rise=0.
- Arithmetic:
  - diff = a - b computed at WIDTH+1 bits, sign-extended if SIGNED=1, zero-extended otherwise; no overflow possible.
  - up = diff > HYST; down = diff < -HYST.
- Latency: all outputs update on the clk edge that samples en=1; one cycle after inputs present.
- en=0: every register holds, pulses drop to 0, the period counter does not advance.
- FSM states: INIT, ABOVE, BELOW.
  - INIT: up -> ABOVE; down -> BELOW; no pulse. Initial relation is not a crossing.
  - BELOW: up -> ABOVE, rise=1. Otherwise stay.
  - ABOVE: down -> BELOW, fall=1. Otherwise stay.
  - Inside the band (|diff| <= HYST) the state is held.
  - With HYST=0, equality never changes state.
- cross_count increments on each rise or fall; wraps from max to 0.
- Period counter increments every enabled sample and saturates at 2^CNT_WIDTH-1; saturation sets period_sat.
- On rise:
  - If have_rise=1: period <= counter+1 (saturated), period_valid=1.
  - Always: counter <= 0, have_rise <= 1.
- The first rise after reset/clear produces no period_valid.
- clear=1 (any en):
  - FSM=INIT, counter=0, have_rise=0, cross_count=0, period_sat=0, rise=fall=period_valid=0.
  - period and eq/lt/gt hold their values.
  - clear has priority over a simultaneous crossing.
- Reset asserted mid-stream: immediate return to reset values. After release, a fresh INIT is required before any pulse.

Decomposition:
- Shared header/package holds:
  - FSM state encodings ST_INIT=2'd0, ST_ABOVE=2'd1, ST_BELOW=2'd2.
  - Default WIDTH/CNT_WIDTH constants, also used by the sine_cos generator and benches.
- One combinational sub-module, sine_cos_hyst_cmp (WIDTH, SIGNED, HYST parameters; a, b in; eq, lt, gt, up, down out), does the extension and subtraction.
- The top holds the FSM, counters and output registers.

Test Plan:
- Reset/INIT: hold reset=0 for 10 cycles, then release with a=100, b=50, en=1. Expect gt=1 one cycle later, FSM ABOVE, rise=0, cross_count=0.
- Signed crossing, WIDTH=16, SIGNED=1, HYST=0: sequence a=-5, b=0 then a=5, b=0. Expect rise pulse on the second sample, cross_count=1. Same bits with SIGNED=0 give no rise (0xFFFB > 0).
- Hysteresis, HYST=4, start BELOW with a=-10, b=0: a=3 -> no pulse; a=4 -> no pulse; a=5 -> rise=1. Then a=-4 -> no fall; a=-5 -> fall=1.
- Period: rises spaced 20 enabled samples apart, with en held 0 for 7 cycles between them. Expect first rise gives no period_valid, second gives period=20 and period_valid=1.
- Saturation/wrap, CNT_WIDTH=4: no rise for 20 samples then rise -> period=15, period_sat=1. Then 17 crossings -> cross_count wraps to 1.
- Clear vs crossing: assert clear on the same cycle a rise condition occurs. Expect rise=0, cross_count=0, FSM INIT. The next sample with up true moves to ABOVE without a pulse.

Source files
------------

// File: rtl/sine_cos_cross_detector_pkg.sv
// Shared constants for the sine/cos generator, its crossing monitor and benches.
package sine_cos_cross_detector_pkg;

  // Default sample and counter widths used across the sine/cos slice.
  localparam int unsigned SC_WIDTH     = 16;
  localparam int unsigned SC_CNT_WIDTH = 16;

  // Crossing monitor states: INIT until the first clear relation is seen.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ABOVE = 2'd1,
    ST_BELOW = 2'd2
  } cross_state_e;

  // Even parity of a state encoding, for use by state-integrity checkers.
  function automatic logic state_parity(input cross_state_e st);
    return ^st;
  endfunction

endpackage

// File: rtl/sine_cos_hyst_cmp.sv
// Combinational comparator: extends a/b by one bit, subtracts, and classifies
// the difference against a symmetric hysteresis band.
module sine_cos_hyst_cmp #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SIGNED = 1,
  parameter int unsigned HYST   = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o,
  output logic             lt_o,
  output logic             gt_o,
  output logic             up_o,
  output logic             down_o
);

  // Band edges at WIDTH+1 bits; HYST < 2^(WIDTH-1) keeps both in range.
  localparam logic signed [WIDTH:0] HYST_POS = $signed((WIDTH+1)'(HYST));
  localparam logic signed [WIDTH:0] HYST_NEG = -HYST_POS;

  logic [WIDTH:0]        a_ext_s;
  logic [WIDTH:0]        b_ext_s;
  logic signed [WIDTH:0] diff_s;

  // Extend both samples by one bit so the difference can never overflow.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext_s = {a_i[WIDTH-1], a_i};
      b_ext_s = {b_i[WIDTH-1], b_i};
    end else begin
      a_ext_s = {1'b0, a_i};
      b_ext_s = {1'b0, b_i};
    end
    diff_s = $signed(a_ext_s - b_ext_s);
  end

  assign eq_o   = (diff_s == {(WIDTH+1){1'b0}});
  assign lt_o   = diff_s[WIDTH];
  assign gt_o   = !diff_s[WIDTH] && (diff_s != {(WIDTH+1){1'b0}});
  assign up_o   = (diff_s > HYST_POS);
  assign down_o = (diff_s < HYST_NEG);

endmodule

// File: rtl/sine_cos_cross_detector.sv
// Streaming crossing monitor for the sine/cos generator: registered relation
// flags, rise/fall pulses, a wrapping crossing count and rise-to-rise period.
module sine_cos_cross_detector
  import sine_cos_cross_detector_pkg::*;
#(
  parameter int unsigned WIDTH     = SC_WIDTH,
  parameter int unsigned SIGNED    = 1,
  parameter int unsigned HYST      = 0,
  parameter int unsigned CNT_WIDTH = SC_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 eq_o,
  output logic                 lt_o,
  output logic                 gt_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic [CNT_WIDTH-1:0] cross_count_o,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic                 period_sat_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic cmp_eq_s, cmp_lt_s, cmp_gt_s, cmp_up_s, cmp_down_s;

  cross_state_e         state_q, state_d;
  logic                 eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic                 rise_q, rise_d, fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cross_count_q, cross_count_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 period_valid_q, period_valid_d;
  logic                 period_sat_q, period_sat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 have_rise_q, have_rise_d;
  logic [CNT_WIDTH-1:0] cnt_inc_s;

  sine_cos_hyst_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED),
    .HYST   (HYST)
  ) u_cmp (
    .a_i    (a_i),
    .b_i    (b_i),
    .eq_o   (cmp_eq_s),
    .lt_o   (cmp_lt_s),
    .gt_o   (cmp_gt_s),
    .up_o   (cmp_up_s),
    .down_o (cmp_down_s)
  );

  // Counter + 1 that sticks at the maximum instead of wrapping.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Next-state logic: FSM transitions, pulses, counters and relation flags.
  always_comb begin
    state_d        = state_q;
    eq_d           = eq_q;
    lt_d           = lt_q;
    gt_d           = gt_q;
    rise_d         = 1'b0;
    fall_d         = 1'b0;
    cross_count_d  = cross_count_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    period_sat_d   = period_sat_q;
    cnt_d          = cnt_q;
    have_rise_d    = have_rise_q;

    if (clear_i) begin
      // Clear wins over any crossing seen on the same sample.
      state_d       = ST_INIT;
      cnt_d         = CNT_ZERO;
      have_rise_d   = 1'b0;
      cross_count_d = CNT_ZERO;
      period_sat_d  = 1'b0;
    end else if (en_i) begin
      eq_d = cmp_eq_s;
      lt_d = cmp_lt_s;
      gt_d = cmp_gt_s;

      case (state_q)
        ST_INIT: begin
          // The first clear relation only seeds the state; it is not a crossing.
          if (cmp_up_s) begin
            state_d = ST_ABOVE;
          end else if (cmp_down_s) begin
            state_d = ST_BELOW;
          end else begin
            state_d = ST_INIT;
          end
        end
        ST_BELOW: begin
          if (cmp_up_s) begin
            state_d = ST_ABOVE;
            rise_d  = 1'b1;
          end else begin
            state_d = ST_BELOW;
          end
        end
        ST_ABOVE: begin
          if (cmp_down_s) begin
            state_d = ST_BELOW;
            fall_d  = 1'b1;
          end else begin
            state_d = ST_ABOVE;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase

      if (rise_d || fall_d) begin
        cross_count_d = cross_count_q + CNT_ONE;
      end else begin
        cross_count_d = cross_count_q;
      end

      if (cnt_q == CNT_MAX) begin
        period_sat_d = 1'b1;
      end else begin
        period_sat_d = period_sat_q;
      end

      if (rise_d) begin
        // The rise sample itself counts toward the period it closes.
        if (have_rise_q) begin
          period_d       = cnt_inc_s;
          period_valid_d = 1'b1;
        end else begin
          period_d       = period_q;
          period_valid_d = 1'b0;
        end
        cnt_d       = CNT_ZERO;
        have_rise_d = 1'b1;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; async reset returns everything to idle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= ST_INIT;
      eq_q           <= 1'b0;
      lt_q           <= 1'b0;
      gt_q           <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      cross_count_q  <= CNT_ZERO;
      period_q       <= CNT_ZERO;
      period_valid_q <= 1'b0;
      period_sat_q   <= 1'b0;
      cnt_q          <= CNT_ZERO;
      have_rise_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      eq_q           <= eq_d;
      lt_q           <= lt_d;
      gt_q           <= gt_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      cross_count_q  <= cross_count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      period_sat_q   <= period_sat_d;
      cnt_q          <= cnt_d;
      have_rise_q    <= have_rise_d;
    end
  end

  assign eq_o           = eq_q;
  assign lt_o           = lt_q;
  assign gt_o           = gt_q;
  assign rise_o         = rise_q;
  assign fall_o         = fall_q;
  assign cross_count_o  = cross_count_q;
  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign period_sat_o   = period_sat_q;

endmodule

// File: tb/tb_sine_cos_cross_detector.sv
// Directed bench: four monitor instances (signed, unsigned, hysteresis,
// narrow counters) share one stimulus stream.
module tb_sine_cos_cross_detector;
  import sine_cos_cross_detector_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        clear;
  logic [15:0] a;
  logic [15:0] b;

  int n_checks;
  int n_errors;

  // Signed, HYST=0, 16-bit counters.
  logic s_eq, s_lt, s_gt, s_rise, s_fall, s_pv, s_sat;
  logic [15:0] s_cnt, s_per;
  // Unsigned, HYST=0.
  logic u_eq, u_lt, u_gt, u_rise, u_fall, u_pv, u_sat;
  logic [15:0] u_cnt, u_per;
  // Signed, HYST=4.
  logic h_eq, h_lt, h_gt, h_rise, h_fall, h_pv, h_sat;
  logic [15:0] h_cnt, h_per;
  // Signed, HYST=0, 4-bit counters.
  logic c_eq, c_lt, c_gt, c_rise, c_fall, c_pv, c_sat;
  logic [3:0] c_cnt, c_per;

  sine_cos_cross_detector #(.WIDTH(16), .SIGNED(1), .HYST(0), .CNT_WIDTH(16)) dut_s (
    .clk_i(clk), .reset_ni(reset_n), .en_i(en), .clear_i(clear), .a_i(a), .b_i(b),
    .eq_o(s_eq), .lt_o(s_lt), .gt_o(s_gt), .rise_o(s_rise), .fall_o(s_fall),
    .cross_count_o(s_cnt), .period_o(s_per), .period_valid_o(s_pv), .period_sat_o(s_sat));

  sine_cos_cross_detector #(.WIDTH(16), .SIGNED(0), .HYST(0), .CNT_WIDTH(16)) dut_u (
    .clk_i(clk), .reset_ni(reset_n), .en_i(en), .clear_i(clear), .a_i(a), .b_i(b),
    .eq_o(u_eq), .lt_o(u_lt), .gt_o(u_gt), .rise_o(u_rise), .fall_o(u_fall),
    .cross_count_o(u_cnt), .period_o(u_per), .period_valid_o(u_pv), .period_sat_o(u_sat));

  sine_cos_cross_detector #(.WIDTH(16), .SIGNED(1), .HYST(4), .CNT_WIDTH(16)) dut_h (
    .clk_i(clk), .reset_ni(reset_n), .en_i(en), .clear_i(clear), .a_i(a), .b_i(b),
    .eq_o(h_eq), .lt_o(h_lt), .gt_o(h_gt), .rise_o(h_rise), .fall_o(h_fall),
    .cross_count_o(h_cnt), .period_o(h_per), .period_valid_o(h_pv), .period_sat_o(h_sat));

  sine_cos_cross_detector #(.WIDTH(16), .SIGNED(1), .HYST(0), .CNT_WIDTH(4)) dut_c (
    .clk_i(clk), .reset_ni(reset_n), .en_i(en), .clear_i(clear), .a_i(a), .b_i(b),
    .eq_o(c_eq), .lt_o(c_lt), .gt_o(c_gt), .rise_o(c_rise), .fall_o(c_fall),
    .cross_count_o(c_cnt), .period_o(c_per), .period_valid_o(c_pv), .period_sat_o(c_sat));

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample, then sample outputs 1 ns after the capturing edge.
  task automatic step(input logic [15:0] av, input logic [15:0] bv, input logic e, input logic c);
    a = av; b = bv; en = e; clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0; en = 1'b0; clear = 1'b0; a = 16'd0; b = 16'd0;

    // Reset held for 10 cycles.
    repeat (10) @(posedge clk);
    #1;
    check_value("rst_flags", {25'd0, s_eq, s_lt, s_gt, s_rise, s_fall, s_pv, s_sat}, 32'd0);
    check_value("rst_count", {16'd0, s_cnt}, 32'd0);
    check_value("rst_period", {16'd0, s_per}, 32'd0);
    check_value("rst_state", {30'd0, dut_s.state_q}, {30'd0, ST_INIT});

    // Release with a=100, b=50: INIT seeds ABOVE without a pulse.
    reset_n = 1'b1;
    step(16'd100, 16'd50, 1'b1, 1'b0);
    check_value("init_gt", {31'd0, s_gt}, 32'd1);
    check_value("init_eqlt", {30'd0, s_eq, s_lt}, 32'd0);
    check_value("init_rise", {31'd0, s_rise}, 32'd0);
    check_value("init_count", {16'd0, s_cnt}, 32'd0);
    check_value("init_state", {30'd0, dut_s.state_q}, {30'd0, ST_ABOVE});

    // Signed vs unsigned crossing: -5 then 5 against 0.
    step(16'd0, 16'd0, 1'b1, 1'b1);
    step(16'hFFFB, 16'd0, 1'b1, 1'b0);
    check_value("sgn_lt", {31'd0, s_lt}, 32'd1);
    check_value("sgn_no_pulse", {30'd0, s_rise, s_fall}, 32'd0);
    check_value("uns_gt", {31'd0, u_gt}, 32'd1);
    step(16'd5, 16'd0, 1'b1, 1'b0);
    check_value("sgn_rise", {31'd0, s_rise}, 32'd1);
    check_value("sgn_count", {16'd0, s_cnt}, 32'd1);
    check_value("uns_no_rise", {31'd0, u_rise}, 32'd0);
    check_value("uns_count", {16'd0, u_cnt}, 32'd0);
    step(16'd5, 16'd0, 1'b1, 1'b0);
    check_value("sgn_rise_drop", {31'd0, s_rise}, 32'd0);

    // Hysteresis band of 4 LSBs.
    step(16'd0, 16'd0, 1'b1, 1'b1);
    step(16'hFFF6, 16'd0, 1'b1, 1'b0);
    check_value("hys_below", {30'd0, dut_h.state_q}, {30'd0, ST_BELOW});
    step(16'd3, 16'd0, 1'b1, 1'b0);
    check_value("hys_a3", {31'd0, h_rise}, 32'd0);
    step(16'd4, 16'd0, 1'b1, 1'b0);
    check_value("hys_a4", {31'd0, h_rise}, 32'd0);
    check_value("hys_a4_state", {30'd0, dut_h.state_q}, {30'd0, ST_BELOW});
    step(16'd5, 16'd0, 1'b1, 1'b0);
    check_value("hys_a5_rise", {31'd0, h_rise}, 32'd1);
    step(16'hFFFC, 16'd0, 1'b1, 1'b0);
    check_value("hys_am4", {31'd0, h_fall}, 32'd0);
    step(16'hFFFB, 16'd0, 1'b1, 1'b0);
    check_value("hys_am5_fall", {31'd0, h_fall}, 32'd1);
    check_value("hys_count", {16'd0, h_cnt}, 32'd2);

    // With HYST=0 an equal sample holds BELOW.
    step(16'd0, 16'd0, 1'b1, 1'b0);
    check_value("eq_flag", {31'd0, s_eq}, 32'd1);
    check_value("eq_hold", {30'd0, dut_s.state_q}, {30'd0, ST_BELOW});

    // Period: two rises 20 enabled samples apart, 7 idle cycles between.
    step(16'd0, 16'd0, 1'b1, 1'b1);
    step(16'hFFFF, 16'd0, 1'b1, 1'b0);
    step(16'd1, 16'd0, 1'b1, 1'b0);
    check_value("per_rise1", {31'd0, s_rise}, 32'd1);
    check_value("per_first_pv", {31'd0, s_pv}, 32'd0);
    for (int i = 0; i < 19; i++) begin
      step(16'hFFFF, 16'd0, 1'b1, 1'b0);
      if (i == 9) begin
        for (int j = 0; j < 7; j++) begin
          step(16'd1, 16'd0, 1'b0, 1'b0);
        end
        check_value("idle_no_rise", {31'd0, s_rise}, 32'd0);
        check_value("idle_state", {30'd0, dut_s.state_q}, {30'd0, ST_BELOW});
      end
    end
    check_value("c_sat_set", {31'd0, c_sat}, 32'd1);
    step(16'd1, 16'd0, 1'b1, 1'b0);
    check_value("per_pv", {31'd0, s_pv}, 32'd1);
    check_value("per_value", {16'd0, s_per}, 32'd20);
    check_value("per_no_sat", {31'd0, s_sat}, 32'd0);
    check_value("c_per_sat", {28'd0, c_per}, 32'd15);
    check_value("c_pv", {31'd0, c_pv}, 32'd1);
    step(16'd1, 16'd0, 1'b1, 1'b0);
    check_value("per_pv_drop", {31'd0, s_pv}, 32'd0);

    // Wrap: 17 crossings on a 4-bit count.
    step(16'd0, 16'd0, 1'b1, 1'b1);
    check_value("clr_sat", {31'd0, c_sat}, 32'd0);
    check_value("clr_per_hold", {28'd0, c_per}, 32'd15);
    step(16'hFFFF, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step(((i % 2) == 0) ? 16'd1 : 16'hFFFF, 16'd0, 1'b1, 1'b0);
    end
    check_value("wrap_c", {28'd0, c_cnt}, 32'd1);
    check_value("wrap_s", {16'd0, s_cnt}, 32'd17);

    // Clear coinciding with a rise condition.
    step(16'hFFFF, 16'd0, 1'b1, 1'b0);
    check_value("pre_clr_fall", {31'd0, s_fall}, 32'd1);
    step(16'd1, 16'd0, 1'b1, 1'b1);
    check_value("clr_rise", {31'd0, s_rise}, 32'd0);
    check_value("clr_count", {16'd0, s_cnt}, 32'd0);
    check_value("clr_state", {30'd0, dut_s.state_q}, {30'd0, ST_INIT});
    check_value("clr_lt_hold", {31'd0, s_lt}, 32'd1);
    step(16'd1, 16'd0, 1'b1, 1'b0);
    check_value("post_clr_rise", {31'd0, s_rise}, 32'd0);
    check_value("post_clr_state", {30'd0, dut_s.state_q}, {30'd0, ST_ABOVE});

    // Asynchronous reset mid-stream.
    step(16'hFFFF, 16'd0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("async_rst_count", {16'd0, s_cnt}, 32'd0);
    check_value("async_rst_flags", {29'd0, s_lt, s_fall, s_gt}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(16'd1, 16'd0, 1'b1, 1'b0);
    check_value("rerun_no_rise", {31'd0, s_rise}, 32'd0);
    check_value("rerun_state", {30'd0, dut_s.state_q}, {30'd0, ST_ABOVE});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
